note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_note_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// note_scheduler: walks a note chart in ROM, spawns notes per lane when their
// frame comes due, and judges key presses against each lane's note age.
//
// Interface timing: there is no valid/ready handshake on this block. The chart
// ROM is a fixed-latency read (chart_data valid one cycle after chart_addr).
// start, spawn, hit and miss are single-cycle pulses. playing and done are levels.
// dbg_state exposes the FSM state for observation.
`timescale 1ns/1ps
module note_scheduler #(
  parameter int CHART_AW = 8,
  parameter int TRAVEL   = 120,
  parameter int WIN      = 6
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic                start,
  input  logic [7:0]          keycode,
  output logic [CHART_AW-1:0] chart_addr,
  input  logic [15:0]         chart_data,
  output logic [4:0]          spawn,
  output logic [4:0]          hit,
  output logic [4:0]          miss,
  output logic [15:0]         score,
  output logic                playing,
  output logic                done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    WAIT_RD    = 3'd2,
    CHECK      = 3'd3,
    WAIT_FRAME = 3'd4,
    DRAIN      = 3'd5,
    DONE       = 3'd6
  } state_t;

  localparam logic [7:0]          AGE_LO    = 8'(TRAVEL - WIN);
  localparam logic [7:0]          AGE_HI    = 8'(TRAVEL + WIN);
  localparam logic [CHART_AW-1:0] ADDR_LAST = {CHART_AW{1'b1}};
  localparam logic [10:0]         FRAME_MAX = 11'h7ff;

  state_t      state_q, state_d;
  logic        fs1, fs2, fs3, frame_tick;
  logic [7:0]  key_prev;
  logic [4:0]  press;
  logic [15:0] entry_q;
  logic [10:0] frame_cnt;
  logic [4:0]  pending;
  logic [7:0]  age [5];
  logic        start_song, advance;
  logic [4:0]  spawn_now, hit_d, miss_d;

  function automatic logic [7:0] lane_key(input int lane);
    case (lane)
      0:       lane_key = 8'h04;
      1:       lane_key = 8'h16;
      2:       lane_key = 8'h07;
      3:       lane_key = 8'h09;
      default: lane_key = 8'h0a;
    endcase
  endfunction

  // Synchronize frame_clk (two flops plus an edge-detect flop) and remember the last keycode.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fs1      <= 1'b0;
      fs2      <= 1'b0;
      fs3      <= 1'b0;
      key_prev <= 8'h00;
    end else begin
      fs1      <= frame_clk;
      fs2      <= fs1;
      fs3      <= fs2;
      key_prev <= keycode;
    end
  end

  assign frame_tick = fs2 & ~fs3;

  // A press is a change of keycode onto a lane key; holding a key is not a press.
  always_comb begin
    press = '0;
    for (int i = 0; i < 5; i++)
      press[i] = (keycode != key_prev) && (keycode == lane_key(i));
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic plus the per-cycle control strobes it implies.
  always_comb begin
    state_d    = state_q;
    start_song = 1'b0;
    spawn_now  = '0;
    advance    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_song = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH:   state_d = WAIT_RD;
      WAIT_RD: state_d = CHECK;
      CHECK: begin
        if (entry_q[15:11] == 5'd0) begin
          state_d = DRAIN;
        end else if (entry_q[10:0] <= frame_cnt) begin
          spawn_now = entry_q[15:11];
          if (chart_addr == ADDR_LAST) begin
            state_d = DRAIN;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: if (frame_tick) state_d = CHECK;
      DRAIN:      if (pending == 5'd0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign playing   = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  // Chart pointer, latched chart entry and the song frame counter.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      chart_addr <= '0;
      entry_q    <= 16'h0000;
      frame_cnt  <= 11'd0;
    end else begin
      if (state_q == WAIT_RD) entry_q <= chart_data;
      if (start_song)   chart_addr <= '0;
      else if (advance) chart_addr <= chart_addr + 1'b1;
      if (start_song)
        frame_cnt <= 11'd0;
      else if (playing && frame_tick && frame_cnt != FRAME_MAX)
        frame_cnt <= frame_cnt + 11'd1;
    end
  end

  // Judge each lane: a replacing spawn misses the old note, a press in the window
  // hits (on the pre-increment age), and a tick past the window end misses.
  always_comb begin
    hit_d  = '0;
    miss_d = '0;
    for (int i = 0; i < 5; i++) begin
      if (spawn_now[i])
        miss_d[i] = pending[i];
      else if (pending[i] && press[i] && age[i] >= AGE_LO && age[i] <= AGE_HI)
        hit_d[i] = 1'b1;
      else if (pending[i] && frame_tick && age[i] == AGE_HI)
        miss_d[i] = 1'b1;
    end
  end

  // Lane state, judgement pulses and the saturating score.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pending <= '0;
      spawn   <= '0;
      hit     <= '0;
      miss    <= '0;
      score   <= 16'h0000;
      for (int i = 0; i < 5; i++) age[i] <= 8'd0;
    end else begin
      spawn <= spawn_now;
      hit   <= hit_d;
      miss  <= miss_d;
      if (start_song) begin
        pending <= '0;
        score   <= 16'h0000;
        for (int i = 0; i < 5; i++) age[i] <= 8'd0;
      end else begin
        if (hit_d != 5'd0 && score != 16'hffff) score <= score + 16'd1;
        for (int i = 0; i < 5; i++) begin
          if (spawn_now[i]) begin
            pending[i] <= 1'b1;
            age[i]     <= 8'd0;
          end else if (hit_d[i] || miss_d[i]) begin
            pending[i] <= 1'b0;
          end else if (pending[i] && frame_tick) begin
            age[i] <= age[i] + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: scenario tasks driving charts, frames and keys into
// note_scheduler, checked against a frame-level model of note ages and windows.
`timescale 1ns/1ps
module tb_note_scheduler;
  localparam int TRAVEL = 120;
  localparam int WIN    = 6;
  localparam int MISS_AGE = TRAVEL + WIN + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [7:0]  chart_addr;
  logic [15:0] chart_data;
  logic [4:0]  spawn, hit, miss;
  logic [15:0] score;
  logic        playing, done;
  logic [2:0]  dbg_state;

  logic [15:0] rom [256];
  logic [7:0]  lane_keys [5] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0a};

  int          tests_run = 0;
  int          fails = 0;
  int          hit_cnt [5];
  int          miss_cnt [5];
  int          both_cnt = 0;
  longint      cyc = 0;
  logic [4:0]  spawn_log [$];
  longint      spawn_cyc [$];
  logic [4:0]  exp_q [$];

  note_scheduler #(.CHART_AW(8), .TRAVEL(TRAVEL), .WIN(WIN)) dut (
    .Clk(clk), .Reset_n(reset_n), .frame_clk(frame_clk), .start(start),
    .keycode(keycode), .chart_addr(chart_addr), .chart_data(chart_data),
    .spawn(spawn), .hit(hit), .miss(miss), .score(score),
    .playing(playing), .done(done), .dbg_state(dbg_state)
  );

  // Clock and reset block
  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    chart_data <= rom[chart_addr];
  end

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (hit[i])  hit_cnt[i]++;
      if (miss[i]) miss_cnt[i]++;
    end
    if (spawn != 5'd0) begin
      spawn_log.push_back(spawn);
      spawn_cyc.push_back(cyc);
    end
    if (spawn != 5'd0 && miss != 5'd0) both_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_clk = 1'b1;
      repeat (3) @(negedge clk);
      frame_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // One frame whose synchronized tick lands on the same edge as a key change
  task automatic frame_with_key(input logic [7:0] k);
    frame_clk = 1'b1;
    repeat (2) @(negedge clk);
    keycode = k;
    @(negedge clk);
    frame_clk = 1'b0;
    @(negedge clk);
    keycode = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_key(input logic [7:0] k);
    keycode = k;
    repeat (2) @(negedge clk);
    keycode = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_song();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_spawn(input int n0);
    int t;
    t = 0;
    while (spawn_log.size() == n0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    tests_run++;
    if (spawn_log.size() == n0) begin
      fails++;
      $display("FAIL spawn_timeout: got no spawn within 40 cycles, expected one");
    end
  endtask

  // Reference: a note is hittable while its age (frames since spawn) is in the window
  function automatic bit in_window(input int a);
    return (a >= TRAVEL - WIN) && (a <= TRAVEL + WIN);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (chart_addr !== 8'd0)  begin fails++; $display("FAIL reset_addr: got %0d expected 0", chart_addr); end
    tests_run++; if (score !== 16'd0)      begin fails++; $display("FAIL reset_score: got %0d expected 0", score); end
    tests_run++; if (spawn !== 5'd0)       begin fails++; $display("FAIL reset_spawn: got %b expected 00000", spawn); end
    tests_run++; if (hit !== 5'd0)         begin fails++; $display("FAIL reset_hit: got %b expected 00000", hit); end
    tests_run++; if (miss !== 5'd0)        begin fails++; $display("FAIL reset_miss: got %b expected 00000", miss); end
    tests_run++; if (playing !== 1'b0)     begin fails++; $display("FAIL reset_playing: got %b expected 0", playing); end
    tests_run++; if (done !== 1'b0)        begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (dbg_state !== 3'd0)   begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_chart_spawn();
    logic [4:0] e;
    int m0, m1;
    clear_rom();
    rom[0] = 16'h0800 | 16'd5;
    rom[1] = 16'h1000 | 16'd5;
    rom[2] = 16'h0000;
    spawn_log.delete(); spawn_cyc.delete();
    exp_q.delete();
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    m0 = miss_cnt[0]; m1 = miss_cnt[1];
    start_song();
    tests_run++; if (playing !== 1'b1) begin fails++; $display("FAIL chart_playing: got %b expected 1", playing); end
    frames(4);
    tests_run++; if (spawn_log.size() != 0) begin fails++; $display("FAIL chart_early_spawn: got %0d spawns expected 0", spawn_log.size()); end
    frames(1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (spawn_log.size() != 2) begin
      fails++; $display("FAIL chart_spawn_count: got %0d expected 2", spawn_log.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        e = exp_q.pop_front();
        tests_run++;
        if (spawn_log[i] !== e) begin fails++; $display("FAIL chart_spawn_%0d: got %b expected %b", i, spawn_log[i], e); end
      end
      tests_run++;
      if (spawn_cyc[1] - spawn_cyc[0] != 3) begin fails++; $display("FAIL chart_spawn_gap: got %0d expected 3", spawn_cyc[1] - spawn_cyc[0]); end
    end
    // start while playing must be ignored
    start_song();
    @(negedge clk);
    tests_run++; if (chart_addr !== 8'd2) begin fails++; $display("FAIL chart_start_ignored: got addr %0d expected 2", chart_addr); end
    tests_run++; if (playing !== 1'b1)    begin fails++; $display("FAIL chart_drain_playing: got %b expected 1", playing); end
    frames(MISS_AGE - 1);
    tests_run++; if (miss_cnt[0] - m0 != 0) begin fails++; $display("FAIL chart_early_miss: got %0d expected 0", miss_cnt[0] - m0); end
    frames(1);
    tests_run++; if (miss_cnt[0] - m0 != 1) begin fails++; $display("FAIL chart_miss_lane0: got %0d expected 1", miss_cnt[0] - m0); end
    tests_run++; if (miss_cnt[1] - m1 != 1) begin fails++; $display("FAIL chart_miss_lane1: got %0d expected 1", miss_cnt[1] - m1); end
    tests_run++; if (done !== 1'b1)    begin fails++; $display("FAIL chart_done: got %b expected 1", done); end
    tests_run++; if (playing !== 1'b0) begin fails++; $display("FAIL chart_not_playing: got %b expected 0", playing); end
  endtask

  task automatic hit_trial(input int a, input bit key_on_tick);
    int h0, m0, n0, rem, exp_score;
    longint c0;
    bit exp_hit;
    clear_rom();
    rom[0] = 16'h0800;
    h0 = hit_cnt[0]; m0 = miss_cnt[0]; n0 = spawn_log.size();
    c0 = cyc;
    start_song();
    wait_spawn(n0);
    tests_run++;
    if (spawn_log.size() > n0 && spawn_cyc[spawn_log.size() - 1] - c0 != 4) begin
      fails++; $display("FAIL spawn_latency: got %0d expected 4", spawn_cyc[spawn_log.size() - 1] - c0);
    end
    frames(a);
    if (key_on_tick) frame_with_key(8'h04);
    else             press_key(8'h04);
    exp_hit = in_window(a);
    exp_score = exp_hit ? 1 : 0;
    tests_run++;
    if (hit_cnt[0] - h0 != exp_score) begin fails++; $display("FAIL hit_age_%0d_tick%0d: got %0d hits expected %0d", a, key_on_tick, hit_cnt[0] - h0, exp_score); end
    tests_run++;
    if (score !== 16'(exp_score)) begin fails++; $display("FAIL score_age_%0d: got %0d expected %0d", a, score, exp_score); end
    if (!exp_hit) begin
      rem = MISS_AGE - a - (key_on_tick ? 1 : 0);
      frames(rem);
      tests_run++;
      if (miss_cnt[0] - m0 != 1) begin fails++; $display("FAIL miss_after_age_%0d: got %0d expected 1", a, miss_cnt[0] - m0); end
    end
    tests_run++;
    if (done !== 1'b1) begin fails++; $display("FAIL done_after_age_%0d: got %b expected 1", a, done); end
  endtask

  task automatic test_hit_window();
    int a;
    hit_trial(120, 1'b0);
    hit_trial(113, 1'b0);
    hit_trial(114, 1'b0);
    hit_trial(126, 1'b0);
    hit_trial(112, 1'b0);
    hit_trial(126, 1'b1);
    hit_trial(112, 1'b1);
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(108, 126);
      hit_trial(a, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_miss();
    int m0, n0;
    clear_rom();
    rom[0] = 16'h2000;
    m0 = miss_cnt[2]; n0 = spawn_log.size();
    start_song();
    wait_spawn(n0);
    frames(MISS_AGE - 1);
    tests_run++; if (miss_cnt[2] - m0 != 0) begin fails++; $display("FAIL lane2_early_miss: got %0d expected 0", miss_cnt[2] - m0); end
    frames(1);
    tests_run++; if (miss_cnt[2] - m0 != 1) begin fails++; $display("FAIL lane2_miss: got %0d expected 1", miss_cnt[2] - m0); end
    tests_run++; if (score !== 16'd0)       begin fails++; $display("FAIL lane2_score: got %0d expected 0", score); end
  endtask

  task automatic test_held_key();
    int h0, n0;
    clear_rom();
    rom[0] = 16'h0800;
    keycode = 8'h04;
    repeat (2) @(negedge clk);
    h0 = hit_cnt[0]; n0 = spawn_log.size();
    start_song();
    wait_spawn(n0);
    frames(TRAVEL);
    tests_run++; if (hit_cnt[0] - h0 != 0) begin fails++; $display("FAIL held_key_hit: got %0d expected 0", hit_cnt[0] - h0); end
    keycode = 8'h00;
    repeat (2) @(negedge clk);
    press_key(8'h04);
    tests_run++; if (hit_cnt[0] - h0 != 1) begin fails++; $display("FAIL held_key_release_hit: got %0d expected 1", hit_cnt[0] - h0); end
    tests_run++; if (score !== 16'd1)      begin fails++; $display("FAIL held_key_score: got %0d expected 1", score); end
  endtask

  task automatic test_all_lanes();
    int h0 [5];
    int m0 [5];
    int order [5];
    int j, tmp, n0, exp_score;
    clear_rom();
    rom[0] = 16'hf800;
    for (int i = 0; i < 5; i++) begin h0[i] = hit_cnt[i]; m0[i] = miss_cnt[i]; order[i] = i; end
    for (int i = 4; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    n0 = spawn_log.size();
    start_song();
    wait_spawn(n0);
    tests_run++; if (spawn_log[spawn_log.size() - 1] !== 5'b11111) begin fails++; $display("FAIL lanes_spawn: got %b expected 11111", spawn_log[spawn_log.size() - 1]); end
    frames($urandom_range(TRAVEL - WIN, TRAVEL));
    press_key(8'h05);
    exp_score = 0;
    for (int i = 0; i < 5; i++) begin
      press_key(lane_keys[order[i]]);
      exp_score++;
      tests_run++;
      if (hit_cnt[order[i]] - h0[order[i]] != 1) begin fails++; $display("FAIL lane%0d_hit: got %0d expected 1", order[i], hit_cnt[order[i]] - h0[order[i]]); end
    end
    press_key(8'h16);
    tests_run++; if (hit_cnt[1] - h0[1] != 1)   begin fails++; $display("FAIL idle_lane_hit: got %0d expected 1", hit_cnt[1] - h0[1]); end
    tests_run++; if (miss_cnt[1] - m0[1] != 0)  begin fails++; $display("FAIL idle_lane_miss: got %0d expected 0", miss_cnt[1] - m0[1]); end
    tests_run++; if (score !== 16'(exp_score))  begin fails++; $display("FAIL lanes_score: got %0d expected %0d", score, exp_score); end
    tests_run++; if (done !== 1'b1)             begin fails++; $display("FAIL lanes_done: got %b expected 1", done); end
  endtask

  task automatic test_replace();
    int m0, b0, n0;
    clear_rom();
    rom[0] = 16'h0800;
    rom[1] = 16'h0800 | 16'd10;
    m0 = miss_cnt[0]; b0 = both_cnt; n0 = spawn_log.size();
    start_song();
    wait_spawn(n0);
    frames(10);
    repeat (2) @(negedge clk);
    tests_run++; if (spawn_log.size() - n0 != 2) begin fails++; $display("FAIL replace_spawns: got %0d expected 2", spawn_log.size() - n0); end
    tests_run++; if (miss_cnt[0] - m0 != 1)      begin fails++; $display("FAIL replace_miss: got %0d expected 1", miss_cnt[0] - m0); end
    tests_run++; if (both_cnt - b0 != 1)         begin fails++; $display("FAIL replace_same_cycle: got %0d expected 1", both_cnt - b0); end
    frames(MISS_AGE - 1);
    tests_run++; if (miss_cnt[0] - m0 != 1)      begin fails++; $display("FAIL replace_new_alive: got %0d expected 1", miss_cnt[0] - m0); end
    frames(1);
    tests_run++; if (miss_cnt[0] - m0 != 2)      begin fails++; $display("FAIL replace_new_miss: got %0d expected 2", miss_cnt[0] - m0); end
  endtask

  task automatic test_reset_mid();
    int n0, mt, ht;
    clear_rom();
    rom[0] = 16'h0800;
    rom[1] = 16'h1000 | 16'd50;
    n0 = spawn_log.size();
    start_song();
    wait_spawn(n0);
    frames(5);
    tests_run++; if (dbg_state !== 3'd4) begin fails++; $display("FAIL mid_state: got %0d expected 4", dbg_state); end
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({spawn, hit, miss, score, chart_addr, playing, done} !== 41'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got %h expected 0", {spawn, hit, miss, score, chart_addr, playing, done});
    end
    reset_n = 1'b1;
    n0 = spawn_log.size();
    mt = 0; ht = 0;
    for (int i = 0; i < 5; i++) begin mt += miss_cnt[i]; ht += hit_cnt[i]; end
    frames(MISS_AGE + 3);
    for (int i = 0; i < 5; i++) begin mt -= miss_cnt[i]; ht -= hit_cnt[i]; end
    tests_run++; if (mt != 0) begin fails++; $display("FAIL mid_no_miss: got %0d expected 0", -mt); end
    tests_run++; if (ht != 0) begin fails++; $display("FAIL mid_no_hit: got %0d expected 0", -ht); end
    tests_run++; if (spawn_log.size() != n0) begin fails++; $display("FAIL mid_no_spawn: got %0d expected 0", spawn_log.size() - n0); end
    tests_run++; if (done !== 1'b0)    begin fails++; $display("FAIL mid_done: got %b expected 0", done); end
    tests_run++; if (playing !== 1'b0) begin fails++; $display("FAIL mid_playing: got %b expected 0", playing); end
  endtask

  task automatic test_score_sat();
    int n0, h1;
    clear_rom();
    rom[0] = 16'h1800;
    n0 = spawn_log.size();
    start_song();
    wait_spawn(n0);
    force dut.score = 16'hfffe;
    @(negedge clk);
    release dut.score;
    @(negedge clk);
    frames(TRAVEL);
    press_key(8'h04);
    tests_run++; if (score !== 16'hffff) begin fails++; $display("FAIL sat_reach: got %h expected ffff", score); end
    h1 = hit_cnt[1];
    press_key(8'h16);
    tests_run++; if (hit_cnt[1] - h1 != 1) begin fails++; $display("FAIL sat_hit: got %0d expected 1", hit_cnt[1] - h1); end
    tests_run++; if (score !== 16'hffff)   begin fails++; $display("FAIL sat_hold: got %h expected ffff", score); end
  endtask

  // Test sequence and final report
  initial begin
    clear_rom();
    @(negedge clk);
    test_reset();
    test_chart_spawn();
    test_hit_window();
    test_miss();
    test_held_key();
    test_all_lanes();
    test_replace();
    test_reset_mid();
    test_score_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
